// File: rtl/board_cover_grid.sv
// Cover-state grid (00 covered, 01 opened, 10 flagged) with cursor updates and a combinational read port.
// Latency: cursor writes land on the next clk edge; cell_val is combinational; opened_cell is one cycle after the opening edge.
// No backpressure: one request per cycle is always accepted. Optional macro COVER_REVEAL_ALL_EN adds reveal_all.
module board_cover_grid #(
    parameter int X_SIZE       = 16,
    parameter int Y_SIZE       = 16,
    parameter int X_COORD_BITS = 4,
    parameter int Y_COORD_BITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flag,
    input  logic                    open,
`ifdef COVER_REVEAL_ALL_EN
    input  logic                    reveal_all,
`endif
    input  logic [X_COORD_BITS-1:0] x_coord,
    input  logic [Y_COORD_BITS-1:0] y_coord,
    input  logic [X_COORD_BITS-1:0] x_pos,
    input  logic [Y_COORD_BITS-1:0] y_pos,
    output logic [1:0]              cell_val,
    output logic                    opened_cell
);

    localparam int CELLS    = X_SIZE * Y_SIZE;
    localparam int IDX_BITS = (CELLS > 1) ? $clog2(CELLS) : 1;

    localparam logic [1:0] COVERED = 2'b00;
    localparam logic [1:0] OPENED  = 2'b01;
    localparam logic [1:0] FLAGGED = 2'b10;

    logic [1:0]          grid [CELLS];
    logic                wr_ok;
    logic                rd_ok;
    logic [IDX_BITS-1:0] wr_idx;
    logic [IDX_BITS-1:0] rd_idx;
    logic [1:0]          cur;

    // Address decode for cursor and scan positions; out-of-range reads return covered.
    always_comb begin
        wr_ok    = (int'(x_pos) < X_SIZE) && (int'(y_pos) < Y_SIZE);
        rd_ok    = (int'(x_coord) < X_SIZE) && (int'(y_coord) < Y_SIZE);
        wr_idx   = IDX_BITS'(int'(y_pos) * X_SIZE + int'(x_pos));
        rd_idx   = IDX_BITS'(int'(y_coord) * X_SIZE + int'(x_coord));
        cur      = wr_ok ? grid[wr_idx] : COVERED;
        cell_val = rd_ok ? grid[rd_idx] : COVERED;
    end

    // Grid state and opened pulse: reset clears, otherwise only the cursor cell may change.
    always_ff @(posedge clk) begin
        opened_cell <= 1'b0;
        if (reset) begin
            for (int i = 0; i < CELLS; i++) begin
                grid[i] <= COVERED;
            end
`ifdef COVER_REVEAL_ALL_EN
        end else if (reveal_all) begin
            // Reveal everything not yet opened, flags included; no pulse so win counting is untouched.
            for (int i = 0; i < CELLS; i++) begin
                if (grid[i] != OPENED) begin
                    grid[i] <= OPENED;
                end
            end
`endif
        end else if (wr_ok && (open ^ flag)) begin
            if (open) begin
                // Only a covered cell opens, so a held open pulses once.
                if (cur == COVERED) begin
                    grid[wr_idx] <= OPENED;
                    opened_cell  <= 1'b1;
                end
            end else begin
                // Flag toggles covered/flagged; opened cells are terminal.
                if (cur == COVERED) begin
                    grid[wr_idx] <= FLAGGED;
                end else if (cur == FLAGGED) begin
                    grid[wr_idx] <= COVERED;
                end
            end
        end
    end

endmodule

// File: tb/tb_board_cover_grid.sv
// Self-checking bench for board_cover_grid: directed scenarios plus random requests vs a cell-state model.
// Latency: each request is checked one edge later; reads are checked combinationally.
// No backpressure in the design; the bench drives one request per cycle.
module tb_board_cover_grid;

    localparam int XS = 16;
    localparam int YS = 16;
    localparam int COVERED = 0;
    localparam int OPENED  = 1;
    localparam int FLAGGED = 2;

    logic       clk;
    logic       reset;
    logic       flag;
    logic       open;
    logic       reveal;
    logic [3:0] x_coord;
    logic [3:0] y_coord;
    logic [3:0] x_pos;
    logic [3:0] y_pos;
    logic [1:0] cell_val;
    logic       opened_cell;

    int tests;
    int errors;
    int model [YS][XS];
    int pulses;

    board_cover_grid dut (
        .clk        (clk),
        .reset      (reset),
        .flag       (flag),
        .open       (open),
`ifdef COVER_REVEAL_ALL_EN
        .reveal_all (reveal),
`endif
        .x_coord    (x_coord),
        .y_coord    (y_coord),
        .x_pos      (x_pos),
        .y_pos      (y_pos),
        .cell_val   (cell_val),
        .opened_cell(opened_cell)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge with the given request levels; the model follows the game rules.
    task automatic cycle(input bit r, input bit f, input bit o, input int x, input int y, input bit ra);
        int exp_pulse;
        @(negedge clk);
        reset = r; flag = f; open = o; reveal = ra;
        x_pos = 4'(x); y_pos = 4'(y);
        exp_pulse = 0;
        if (r) begin
            foreach (model[i, j]) model[i][j] = COVERED;
`ifdef COVER_REVEAL_ALL_EN
        end else if (ra) begin
            foreach (model[i, j]) model[i][j] = OPENED;
`endif
        end else if (x < XS && y < YS) begin
            if (o && !f && model[y][x] == COVERED) begin
                model[y][x] = OPENED;
                exp_pulse = 1;
            end else if (f && !o) begin
                if (model[y][x] == COVERED)      model[y][x] = FLAGGED;
                else if (model[y][x] == FLAGGED) model[y][x] = COVERED;
            end
        end
        @(posedge clk);
        #1;
        if (opened_cell === 1'b1) pulses++;
        check("opened_cell", int'(opened_cell), exp_pulse);
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0);
    endtask

    // Reads are done with requests idle so no edge during the read changes state.
    task automatic rd(input int x, input int y);
        reset = 0; flag = 0; open = 0; reveal = 0;
        x_coord = 4'(x); y_coord = 4'(y);
        #1;
        check($sformatf("cell_val(%0d,%0d)", x, y), int'(cell_val), model[y][x]);
    endtask

    task automatic scan_all();
        int bad;
        bad = 0;
        reset = 0; flag = 0; open = 0; reveal = 0;
        for (int y = 0; y < YS; y++) begin
            for (int x = 0; x < XS; x++) begin
                x_coord = 4'(x); y_coord = 4'(y);
                #1;
                if (int'(cell_val) != model[y][x]) bad++;
            end
        end
        check("scan_bad_cells", bad, 0);
    endtask

    initial begin
        int p0;
        tests = 0; errors = 0; pulses = 0;
        reset = 1; flag = 0; open = 0; reveal = 0;
        x_coord = 0; y_coord = 0; x_pos = 0; y_pos = 0;
        foreach (model[i, j]) model[i][j] = COVERED;

        // Reset for two cycles, then the whole grid must read covered.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        idle();
        scan_all();

        // Single open at (1,0).
        cycle(0, 0, 1, 1, 0, 0);
        idle();
        rd(1, 0); rd(0, 0);

        // Flag toggling at (3,3).
        cycle(0, 1, 0, 3, 3, 0); idle(); rd(3, 3);
        cycle(0, 0, 1, 3, 3, 0); idle(); rd(3, 3);
        cycle(0, 1, 0, 3, 3, 0); idle(); rd(3, 3);
        cycle(0, 0, 1, 3, 3, 0); idle(); rd(3, 3);

        // Open held 5 cycles at (15,15): a single pulse; later flag leaves it opened.
        p0 = pulses;
        for (int k = 0; k < 5; k++) cycle(0, 0, 1, 15, 15, 0);
        idle();
        check("held_open_pulses", pulses - p0, 1);
        cycle(0, 1, 0, 15, 15, 0); idle(); rd(15, 15);

        // Simultaneous flag and open is ignored; reset clears an opened cell.
        cycle(0, 1, 1, 7, 2, 0); idle(); rd(7, 2);
        cycle(0, 0, 1, 7, 2, 0); idle(); rd(7, 2);
        cycle(1, 0, 0, 0, 0, 0); rd(7, 2);
        idle();
        scan_all();

`ifdef COVER_REVEAL_ALL_EN
        cycle(0, 1, 0, 0, 0, 0);
        cycle(0, 0, 1, 1, 0, 0);
        idle();
        cycle(0, 1, 1, 5, 5, 1);
        idle();
        scan_all();
        cycle(1, 0, 0, 0, 0, 0);
        idle();
`endif

        // Random requests, mostly single-cycle, with an occasional reset.
        for (int n = 0; n < 600; n++) begin
            int sel;
            bit r, f, o;
            sel = int'($urandom_range(0, 99));
            r = (sel == 0);
            f = (sel >= 1 && sel < 30) || (sel >= 90);
            o = (sel >= 30 && sel < 60) || (sel >= 95);
            cycle(r, f, o, int'($urandom_range(0, XS - 1)), int'($urandom_range(0, YS - 1)), 1'b0);
            if (n % 4 == 3) rd(int'($urandom_range(0, XS - 1)), int'($urandom_range(0, YS - 1)));
        end
        idle();
        scan_all();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/board_cover_grid.md
Name: board_cover_grid

Overview:
- Cover-state memory for the minesweeper playfield. Holds one 2-bit cover state per cell.
- Applies open and flag requests at the cursor position (x_pos, y_pos).
- Provides a combinational read port at the display scan position (x_coord, y_coord).
- Sits beside the mine board. The top level combines the two into the apparent cell value and counts opened cells for win detection.

Parameters:
- X_SIZE, 16, number of columns.
- Y_SIZE, 16, number of rows.
- X_COORD_BITS, 4, width of x coordinates.
- Y_COORD_BITS, 4, width of y coordinates.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; clears the grid.
- flag  input  1  flag-toggle request strobe at cursor.
- open  input  1  open request strobe at cursor.
- x_coord  input  X_COORD_BITS  read column (display scan).
- y_coord  input  Y_COORD_BITS  read row (display scan).
- x_pos  input  X_COORD_BITS  cursor column.
- y_pos  input  Y_COORD_BITS  cursor row.
- cell_val  output  2  cover state of the cell at (x_coord, y_coord).
- opened_cell  output  1  one-cycle pulse when a cell transitions to opened.

Interface:
- One clock (clk); reset is synchronous and active-high.

Behaviour:
- Cell encoding:
  - 2'b00 covered.
  - 2'b01 opened (bit0 = opened).
  - 2'b10 flagged (bit1 = flagged).
  - 2'b11 never stored.
- Storage: X_SIZE*Y_SIZE entries, index = y*X_SIZE + x.
- Reset (synchronous, on a rising clk edge with reset=1):
  - All cells become 00; opened_cell <= 0.
  - flag and open are ignored in that cycle.
- Each edge with reset=0, the cursor cell C = (x_pos, y_pos) is updated as follows:
  - open=1, flag=0, C==00: C <= 01; opened_cell <= 1.
  - open=1, flag=0, C==10 or 01: no change; opened_cell <= 0.
  - flag=1, open=0, C==00: C <= 10.
  - flag=1, open=0, C==10: C <= 00.
  - flag=1, open=0, C==01: no change.
  - flag=1 and open=1 together: no change; opened_cell <= 0.
  - Neither asserted: no change; opened_cell <= 0.
- opened_cell is registered. It is high for exactly one cycle, the cycle after the edge that wrote 01.
- open held high across several cycles opens the cell once only; opened_cell is a single pulse.
- flag is level-sampled: each cycle it is high toggles a covered/flagged cell. Callers must drive single-cycle pulses.
- Cursor out of range (x_pos >= X_SIZE or y_pos >= Y_SIZE): request ignored, opened_cell <= 0.
- Read port:
  - cell_val is purely combinational from (x_coord, y_coord) and the current grid.
  - It reflects a write in the cycle after that write's edge.
  - An out-of-range read returns 00.
- Only the cursor cell changes per cycle. No flood fill in this block.
- Opened is terminal until reset.

Optional Feature:
- Macro COVER_REVEAL_ALL_EN.
- When defined:
  - Adds input reveal_all (1 bit).
  - On an edge with reset=0 and reveal_all=1, every cell that is 00 or 10 becomes 01 in that single cycle.
  - opened_cell <= 0 for that cycle.
  - reveal_all has priority over flag/open.
  - Used by the top level to show the board on LOSE.
- When undefined: no reveal_all port; behaviour exactly as above.

Test Plan:
- Reset held 2 cycles, then released -> cell_val==00 for all 256 (x_coord, y_coord) scans; opened_cell==0.
- x_pos=1, y_pos=0, open pulsed 1 cycle -> next cycle opened_cell==1 for one cycle; read (1,0) gives 01; read (0,0) still gives 00.
- Flag toggle at (3,3):
  - flag pulse at (3,3) -> read gives 10.
  - open pulse there -> stays 10, no opened_cell.
  - second flag pulse -> 00.
  - open pulse -> 01 with opened_cell pulse.
- Open held high 5 cycles at (15,15) -> exactly one opened_cell pulse; cell 01. A subsequent flag pulse leaves it 01.
- flag and open both high at (7,2) -> cell stays 00, no pulse. Reset asserted after opening (7,2) -> cell returns to 00 on that edge.
- With COVER_REVEAL_ALL_EN: flag (0,0), open (1,0), pulse reveal_all -> all 256 cells read 01; opened_cell stays 0.
